// File: rtl/store_buffer_pkg.sv
// Shared types and helpers for the posted-write store buffer.
package store_buffer_pkg;

    localparam int SB_ADDR_WIDTH = 8;
    localparam int SB_DATA_WIDTH = 32;

    typedef struct packed {
        logic [SB_ADDR_WIDTH-1:0] address;
        logic [SB_DATA_WIDTH-1:0] data;
    } sb_entry_t;

    function automatic int ptr_width(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

endpackage

// File: rtl/store_fwd_match.sv
// Youngest-match search over buffered stores for load forwarding.
module store_fwd_match
    import store_buffer_pkg::*;
#(
    parameter int DEPTH      = 4,
    parameter int ADDR_WIDTH = SB_ADDR_WIDTH,
    parameter int DATA_WIDTH = SB_DATA_WIDTH
) (
    input  logic [DEPTH-1:0][ADDR_WIDTH-1:0] entry_address,
    input  logic [DEPTH-1:0][DATA_WIDTH-1:0] entry_data,
    input  logic [DEPTH-1:0]                 valid,
    input  logic [ptr_width(DEPTH)-1:0]      rd_ptr,
    input  logic [ADDR_WIDTH-1:0]            cpu_r_address,
    output logic                             hit,
    output logic [DATA_WIDTH-1:0]            hit_data
);

    localparam int PW = ptr_width(DEPTH);

    // Walk oldest to youngest from the head so the last match wins.
    always_comb begin
        logic [PW-1:0] idx;
        hit      = 1'b0;
        hit_data = '0;
        idx      = '0;
        for (int k = 0; k < DEPTH; k++) begin
            idx = rd_ptr + PW'(k);
            if (valid[idx] && entry_address[idx] == cpu_r_address) begin
                hit      = 1'b1;
                hit_data = entry_data[idx];
            end
        end
    end

endmodule

// File: rtl/store_buffer.sv
// Posted-write FIFO between CPU data port and data memory,
// with store-to-load forwarding of pending entries.
module store_buffer
    import store_buffer_pkg::*;
#(
    parameter int DEPTH      = 4,
    parameter int ADDR_WIDTH = SB_ADDR_WIDTH,
    parameter int DATA_WIDTH = SB_DATA_WIDTH
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  cpu_w_enable,
    input  logic [ADDR_WIDTH-1:0] cpu_w_address,
    input  logic [DATA_WIDTH-1:0] cpu_w_data,
    output logic                  cpu_stall,
    input  logic [ADDR_WIDTH-1:0] cpu_r_address,
    output logic [DATA_WIDTH-1:0] cpu_r_data,
    output logic                  mem_w_enable,
    output logic [ADDR_WIDTH-1:0] mem_w_address,
    output logic [DATA_WIDTH-1:0] mem_w_data,
    input  logic                  mem_w_ready,
    output logic [ADDR_WIDTH-1:0] mem_r_address,
    input  logic [DATA_WIDTH-1:0] mem_r_data,
    input  logic                  flush,
    output logic                  empty
);

    localparam int PW = ptr_width(DEPTH);
    localparam int CW = PW + 1;

    logic [PW-1:0]                  rd_ptr;
    logic [PW-1:0]                  wr_ptr;
    logic [CW-1:0]                  count;
    logic [DEPTH-1:0]               valid;
    logic [DEPTH-1:0]               valid_nxt;
    logic [DEPTH-1:0][ADDR_WIDTH-1:0] addr_q;
    logic [DEPTH-1:0][DATA_WIDTH-1:0] data_q;

    logic                  full;
    logic                  push;
    logic                  pop;
    logic                  hit;
    logic [DATA_WIDTH-1:0] hit_data;

    assign full  = (count == CW'(DEPTH));
    assign empty = (count == '0);

    // A pop in the same cycle never frees room for a push.
    assign cpu_stall = cpu_w_enable && (full || flush);
    assign push      = cpu_w_enable && !cpu_stall;

    assign mem_w_enable  = !empty;
    assign mem_w_address = empty ? '0 : addr_q[rd_ptr];
    assign mem_w_data    = empty ? '0 : data_q[rd_ptr];
    assign pop           = mem_w_enable && mem_w_ready;

    assign mem_r_address = cpu_r_address;
    assign cpu_r_data    = hit ? hit_data : mem_r_data;

    always_comb begin
        valid_nxt = valid;
        if (pop) begin
            valid_nxt[rd_ptr] = 1'b0;
        end
        if (push) begin
            valid_nxt[wr_ptr] = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
            valid  <= '0;
        end else begin
            valid <= valid_nxt;
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            unique case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            addr_q[wr_ptr] <= cpu_w_address;
            data_q[wr_ptr] <= cpu_w_data;
        end
    end

    store_fwd_match #(
        .DEPTH      (DEPTH),
        .ADDR_WIDTH (ADDR_WIDTH),
        .DATA_WIDTH (DATA_WIDTH)
    ) u_fwd (
        .entry_address (addr_q),
        .entry_data    (data_q),
        .valid         (valid),
        .rd_ptr        (rd_ptr),
        .cpu_r_address (cpu_r_address),
        .hit           (hit),
        .hit_data      (hit_data)
    );

endmodule
